// File: rtl/memtrace_req_serializer.sv
// memtrace_req_serializer
//
// Collects up to NUM_LANES trace requests per cycle into per-lane FIFOs and
// issues them one at a time on a single memory request port. Lanes are served
// round-robin; every issued request is tagged with the lowest free source ID,
// and the ID stays busy until its response returns.
//
// Handshake semantics (all ports): a transfer happens on a rising clock edge
// where valid and ready are both high. Once req_valid is raised it stays high,
// and req_lane/req_source/payload stay constant, until req_ready is seen.
// in_ready is a one-cycle look-ahead: in_ready high in cycle t guarantees that
// every lane asserting in_valid in cycle t+1 is stored. resp_valid is always
// accepted.
//
// Ports:
//   clock, reset            clock; synchronous active-high reset
//   in_ready                back-pressure to the trace source
//   in_valid/address/is_store/size/data   per-lane requests, lane g in slice g
//   in_finished             trace source exhausted
//   req_valid/req_ready     memory request handshake
//   req_address/is_store/size/data        head entry of the granted lane
//   req_lane, req_source    granted lane and allocated source ID
//   resp_valid, resp_source returned response
//   inflight                number of busy source IDs
//   done                    sticky completion flag
//   err_overflow, err_resp  sticky error flags
module memtrace_req_serializer #(
    parameter int NUM_LANES    = 4,
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int SIZE_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_INFLIGHT = 8,
    localparam int LANE_W      = $clog2(NUM_LANES),
    localparam int SRC_W       = $clog2(MAX_INFLIGHT)
) (
    input  logic                             clock,
    input  logic                             reset,
    output logic                             in_ready,
    input  logic [NUM_LANES-1:0]             in_valid,
    input  logic [ADDR_WIDTH*NUM_LANES-1:0]  in_address,
    input  logic [NUM_LANES-1:0]             in_is_store,
    input  logic [SIZE_WIDTH*NUM_LANES-1:0]  in_size,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]  in_data,
    input  logic                             in_finished,
    output logic                             req_valid,
    input  logic                             req_ready,
    output logic [ADDR_WIDTH-1:0]            req_address,
    output logic                             req_is_store,
    output logic [SIZE_WIDTH-1:0]            req_size,
    output logic [DATA_WIDTH-1:0]            req_data,
    output logic [LANE_W-1:0]                req_lane,
    output logic [SRC_W-1:0]                 req_source,
    input  logic                             resp_valid,
    input  logic [SRC_W-1:0]                 resp_source,
    output logic [SRC_W:0]                   inflight,
    output logic                             done,
    output logic                             err_overflow,
    output logic                             err_resp
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Lane FIFO storage and pointers
    logic [ADDR_WIDTH-1:0] fifo_addr  [NUM_LANES][FIFO_DEPTH];
    logic                  fifo_store [NUM_LANES][FIFO_DEPTH];
    logic [SIZE_WIDTH-1:0] fifo_size  [NUM_LANES][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data  [NUM_LANES][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr     [NUM_LANES];
    logic [PTR_W-1:0]      rd_ptr     [NUM_LANES];
    logic [CNT_W-1:0]      count      [NUM_LANES];

    logic [LANE_W-1:0]       rr_ptr;
    logic [MAX_INFLIGHT-1:0] busy;
    logic                    fin_seen;

    // Stall lock: remembers the presented grant/ID while the port is stalled
    logic                    locked;
    logic [LANE_W-1:0]       lock_lane;
    logic [SRC_W-1:0]        lock_src;

    logic [NUM_LANES-1:0]    push_vec;
    logic [NUM_LANES-1:0]    pop_vec;
    logic                    all_empty;
    logic                    arb_found;
    logic [LANE_W-1:0]       arb_grant;
    logic [LANE_W-1:0]       scan_idx;
    logic [SRC_W-1:0]        free_id;
    logic [LANE_W-1:0]       grant;
    logic [SRC_W-1:0]        source;
    logic                    fire;
    logic                    resp_hit;
    logic [MAX_INFLIGHT-1:0] busy_next;

    // in_ready leaves one slot of headroom per lane for the beat that the
    // source may already have launched when it sampled in_ready.
    always_comb begin
        in_ready  = 1'b1;
        all_empty = 1'b1;
        for (int g = 0; g < NUM_LANES; g++) begin
            if (count[g] > CNT_W'(FIFO_DEPTH - 2)) in_ready = 1'b0;
            if (count[g] != '0) all_empty = 1'b0;
        end
    end

    // Round-robin scan starting at rr_ptr; LANE_W-bit addition wraps modulo NUM_LANES
    always_comb begin
        arb_found = 1'b0;
        arb_grant = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            scan_idx = rr_ptr + LANE_W'(k);
            if (!arb_found && (count[scan_idx] != '0)) begin
                arb_found = 1'b1;
                arb_grant = scan_idx;
            end
        end
    end

    // Lowest-index free source ID (scan from the top so the lowest wins)
    always_comb begin
        free_id = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            if (!busy[i]) free_id = SRC_W'(i);
        end
    end

    assign grant     = locked ? lock_lane : arb_grant;
    assign source    = locked ? lock_src  : free_id;
    assign req_valid = arb_found && (inflight < (SRC_W + 1)'(MAX_INFLIGHT));
    assign fire      = req_valid && req_ready;

    // Outputs read as zero whenever no request is presented
    assign req_lane     = req_valid ? grant  : '0;
    assign req_source   = req_valid ? source : '0;
    assign req_address  = req_valid ? fifo_addr[grant][rd_ptr[grant]]  : '0;
    assign req_is_store = req_valid ? fifo_store[grant][rd_ptr[grant]] : 1'b0;
    assign req_size     = req_valid ? fifo_size[grant][rd_ptr[grant]]  : '0;
    assign req_data     = req_valid ? fifo_data[grant][rd_ptr[grant]]  : '0;

    // A full lane drops its input even if it pops this cycle
    always_comb begin
        for (int g = 0; g < NUM_LANES; g++) begin
            push_vec[g] = in_valid[g] && (count[g] != CNT_W'(FIFO_DEPTH));
            pop_vec[g]  = fire && (grant == LANE_W'(g));
        end
    end

    // A response can never hit the ID being issued this cycle: that ID is free
    always_comb begin
        resp_hit  = resp_valid && busy[resp_source];
        busy_next = busy;
        if (resp_hit) busy_next[resp_source] = 1'b0;
        if (fire)     busy_next[source]      = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int g = 0; g < NUM_LANES; g++) begin
                wr_ptr[g] <= '0;
                rd_ptr[g] <= '0;
                count[g]  <= '0;
            end
            rr_ptr       <= '0;
            busy         <= '0;
            inflight     <= '0;
            fin_seen     <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
            err_resp     <= 1'b0;
            locked       <= 1'b0;
            lock_lane    <= '0;
            lock_src     <= '0;
        end else begin
            for (int g = 0; g < NUM_LANES; g++) begin
                if (push_vec[g]) begin
                    fifo_addr[g][wr_ptr[g]]  <= in_address[g*ADDR_WIDTH +: ADDR_WIDTH];
                    fifo_store[g][wr_ptr[g]] <= in_is_store[g];
                    fifo_size[g][wr_ptr[g]]  <= in_size[g*SIZE_WIDTH +: SIZE_WIDTH];
                    fifo_data[g][wr_ptr[g]]  <= in_data[g*DATA_WIDTH +: DATA_WIDTH];
                    wr_ptr[g]                <= wr_ptr[g] + 1'b1;
                end
                if (pop_vec[g]) rd_ptr[g] <= rd_ptr[g] + 1'b1;
                count[g] <= count[g] + CNT_W'(push_vec[g]) - CNT_W'(pop_vec[g]);
                if (in_valid[g] && !push_vec[g]) err_overflow <= 1'b1;
            end

            if (fire) rr_ptr <= grant + 1'b1;

            busy     <= busy_next;
            inflight <= inflight + (SRC_W + 1)'(fire) - (SRC_W + 1)'(resp_hit);
            if (resp_valid && !resp_hit) err_resp <= 1'b1;

            locked <= req_valid && !req_ready;
            if (req_valid && !req_ready) begin
                lock_lane <= grant;
                lock_src  <= source;
            end

            if (in_finished) fin_seen <= 1'b1;
            if (fin_seen && all_empty && !req_valid && (inflight == '0)) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memtrace_req_serializer.sv
// Testbench for memtrace_req_serializer. A queue-based reference model runs in
// the driver; expected issued requests and per-cycle status go into queues
// that a separate monitor drains at the falling edge.
module tb_memtrace_req_serializer;

    localparam int NL    = 4;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int SW    = 8;
    localparam int FD    = 4;
    localparam int MI    = 8;
    localparam int LW    = 2;
    localparam int SRCW  = 3;
    localparam int ENT_W = AW + 1 + SW + DW;

    typedef struct packed {
        logic [LW-1:0]   lane;
        logic [SRCW-1:0] src;
        logic [AW-1:0]   addr;
        logic            st;
        logic [SW-1:0]   size;
        logic [DW-1:0]   data;
    } req_t;
    localparam int REQ_W = $bits(req_t);

    typedef struct packed {
        logic            ir;
        logic            v;
        logic [SRCW:0]   infl;
        logic            dn;
        logic            eo;
        logic            er;
        logic [LW-1:0]   lane;
        logic [SRCW-1:0] src;
    } st_t;

    // ---------------- clock / reset / DUT ----------------
    logic              clock;
    logic              reset;
    logic              in_ready;
    logic [NL-1:0]     in_valid;
    logic [AW*NL-1:0]  in_address;
    logic [NL-1:0]     in_is_store;
    logic [SW*NL-1:0]  in_size;
    logic [DW*NL-1:0]  in_data;
    logic              in_finished;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_address;
    logic              req_is_store;
    logic [SW-1:0]     req_size;
    logic [DW-1:0]     req_data;
    logic [LW-1:0]     req_lane;
    logic [SRCW-1:0]   req_source;
    logic              resp_valid;
    logic [SRCW-1:0]   resp_source;
    logic [SRCW:0]     inflight;
    logic              done;
    logic              err_overflow;
    logic              err_resp;

    memtrace_req_serializer #(
        .NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW),
        .FIFO_DEPTH(FD), .MAX_INFLIGHT(MI)
    ) dut (
        .clock(clock), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
        .in_address(in_address), .in_is_store(in_is_store), .in_size(in_size),
        .in_data(in_data), .in_finished(in_finished), .req_valid(req_valid),
        .req_ready(req_ready), .req_address(req_address), .req_is_store(req_is_store),
        .req_size(req_size), .req_data(req_data), .req_lane(req_lane),
        .req_source(req_source), .resp_valid(resp_valid), .resp_source(resp_source),
        .inflight(inflight), .done(done), .err_overflow(err_overflow), .err_resp(err_resp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [REQ_W-1:0] exp_q[$];
    st_t              st_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    bit               mon_en   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Lane queues hold {addr, is_store, size, data}; busy IDs as a flag array.
    logic [ENT_W-1:0] mq [NL][$];
    bit               mbusy [MI];
    int               m_rr = 0;
    bit               held = 0;
    int               held_lane = 0;
    int               held_src = 0;
    bit               m_fin = 0, m_done = 0, m_eo = 0, m_er = 0;
    bit               m_ir_prev = 1;

    function automatic int busy_cnt();
        int n = 0;
        for (int i = 0; i < MI; i++) if (mbusy[i]) n++;
        return n;
    endfunction

    function automatic bit model_idle();
        bit idle = (busy_cnt() == 0);
        for (int g = 0; g < NL; g++) if (mq[g].size() != 0) idle = 0;
        return idle;
    endfunction

    // One clock cycle: predict this cycle's outputs, drive inputs, advance model.
    task automatic step(input logic [NL-1:0] vmask, input logic rdy, input logic rv,
                        input int rs, input logic fin, input logic rst);
        logic [ENT_W-1:0] ent [NL];
        int   sz [NL];
        bit   any, ev, ir, all_empty, hit;
        int   lane, src, bc, cand;
        st_t  s;

        bc = busy_cnt();
        any = 0; all_empty = 1; ir = 1;
        for (int g = 0; g < NL; g++) begin
            sz[g] = mq[g].size();
            if (sz[g] != 0) begin any = 1; all_empty = 0; end
            if (sz[g] > FD - 2) ir = 0;
        end
        ev = any && (bc < MI);
        lane = 0; src = 0;
        if (ev) begin
            if (held) begin
                lane = held_lane; src = held_src;
            end else begin
                for (int k = NL - 1; k >= 0; k--) begin
                    cand = (m_rr + k) % NL;
                    if (sz[cand] != 0) lane = cand;
                end
                for (int i = MI - 1; i >= 0; i--) if (!mbusy[i]) src = i;
            end
        end
        s.ir = ir; s.v = ev; s.infl = (SRCW+1)'(bc); s.dn = m_done; s.eo = m_eo;
        s.er = m_er; s.lane = LW'(lane); s.src = SRCW'(src);
        st_q.push_back(s);
        m_ir_prev = ir;

        for (int g = 0; g < NL; g++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic          st;
            logic [SW-1:0] z;
            a  = {$urandom, $urandom};
            d  = {$urandom, $urandom};
            st = 1'($urandom_range(0, 1));
            z  = SW'($urandom_range(0, 255));
            ent[g] = {a, st, z, d};
            in_address[g*AW +: AW] = a;
            in_is_store[g]         = st;
            in_size[g*SW +: SW]    = z;
            in_data[g*DW +: DW]    = d;
        end
        in_valid    = vmask;
        req_ready   = rdy;
        resp_valid  = rv;
        resp_source = SRCW'(rs);
        in_finished = fin;
        reset       = rst;

        if (rst) begin
            for (int g = 0; g < NL; g++) mq[g].delete();
            for (int i = 0; i < MI; i++) mbusy[i] = 0;
            m_rr = 0; held = 0; m_fin = 0; m_done = 0; m_eo = 0; m_er = 0;
        end else begin
            hit = rv && mbusy[rs];
            if (rv && !hit) m_er = 1;
            if (m_fin && all_empty && !ev && bc == 0) m_done = 1;
            if (fin) m_fin = 1;
            if (ev && rdy) begin
                exp_q.push_back({LW'(lane), SRCW'(src), mq[lane][0]});
                void'(mq[lane].pop_front());
                m_rr = (lane + 1) % NL;
                held = 0;
            end else if (ev) begin
                held = 1; held_lane = lane; held_src = src;
            end else begin
                held = 0;
            end
            if (hit) mbusy[rs] = 0;
            if (ev && rdy) mbusy[src] = 1;
            for (int g = 0; g < NL; g++) begin
                if (vmask[g]) begin
                    if (sz[g] == FD) m_eo = 1;
                    else mq[g].push_back(ent[g]);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Respond to a random busy ID (or none) and return the choice
    task automatic pick_resp(output bit rv, output int rs);
        int ids[$];
        rv = 0; rs = 0;
        for (int i = 0; i < MI; i++) if (mbusy[i]) ids.push_back(i);
        if (ids.size() != 0 && $urandom_range(0, 3) != 0) begin
            rv = 1; rs = ids[$urandom_range(0, ids.size() - 1)];
        end
    endtask

    task automatic drain();
        bit rv; int rs;
        for (int c = 0; c < 60 && !model_idle(); c++) begin
            pick_resp(rv, rs);
            step('0, 1'b1, rv, rs, 1'b0, 1'b0);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        st_t  s;
        req_t r;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (st_q.size() != 0) begin
                    s = st_q.pop_front();
                    chk("in_ready", 64'(in_ready), 64'(s.ir));
                    chk("req_valid", 64'(req_valid), 64'(s.v));
                    chk("inflight", 64'(inflight), 64'(s.infl));
                    chk("done", 64'(done), 64'(s.dn));
                    chk("err_overflow", 64'(err_overflow), 64'(s.eo));
                    chk("err_resp", 64'(err_resp), 64'(s.er));
                    if (s.v) begin
                        chk("req_lane", 64'(req_lane), 64'(s.lane));
                        chk("req_source", 64'(req_source), 64'(s.src));
                    end
                end
                if (req_valid && req_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_fire: got lane %0d src %0d required no request",
                                 req_lane, req_source);
                    end else begin
                        r = exp_q.pop_front();
                        chk("fire_lane", 64'(req_lane), 64'(r.lane));
                        chk("fire_source", 64'(req_source), 64'(r.src));
                        chk("fire_address", req_address, r.addr);
                        chk("fire_is_store", 64'(req_is_store), 64'(r.st));
                        chk("fire_size", 64'(req_size), 64'(r.size));
                        chk("fire_data", req_data, r.data);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit rv; int rs;
        logic [NL-1:0] vm;
        reset = 1'b1; in_valid = '0; in_address = '0; in_is_store = '0; in_size = '0;
        in_data = '0; in_finished = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
        resp_source = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_req_address", req_address, 64'd0);
        chk("reset_req_data", req_data, 64'd0);
        chk("reset_req_size", 64'(req_size), 64'd0);
        chk("reset_req_is_store", 64'(req_is_store), 64'd0);
        chk("reset_req_lane", 64'(req_lane), 64'd0);
        mon_en = 1;

        // single lane: lane 2, issue, respond
        step(4'b0100, 1, 0, 0, 0, 0);
        step(4'b0000, 1, 0, 0, 0, 0);
        step(4'b0000, 1, 1, 0, 0, 0);
        step(4'b0000, 1, 0, 0, 0, 0);

        // round-robin over all lanes, then contention after wrap
        step(4'b1111, 1, 0, 0, 0, 0);
        repeat (5) step(4'b0000, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1, 1, i, 0, 0);
        step(4'b1001, 1, 0, 0, 0, 0);
        drain();

        // stall with two lanes pending
        step(4'b0110, 0, 0, 0, 0, 0);
        repeat (5) step(4'b0000, 0, 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0, 0);
        repeat (3) step(4'b0000, 1, 0, 0, 0, 0);
        drain();

        // back-pressure on lane 0 with the port stalled, then forced overflow
        for (int c = 0; c < 8; c++) step(m_ir_prev ? 4'b0001 : 4'b0000, 0, 0, 0, 0, 0);
        step(4'b0001, 0, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);

        // ID exhaustion, free ID 5, stale response to 5, reissue 5
        step(4'b1111, 1, 0, 0, 0, 0);
        step(4'b1111, 1, 0, 0, 0, 0);
        step(4'b0001, 1, 0, 0, 0, 0);
        repeat (8) step(4'b0000, 1, 0, 0, 0, 0);
        step(4'b0000, 0, 1, 5, 0, 0);
        step(4'b0000, 0, 1, 5, 0, 0);
        step(4'b0000, 1, 0, 0, 0, 0);
        step(4'b0000, 1, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);

        // done with three outstanding requests
        step(4'b0111, 1, 0, 0, 0, 0);
        repeat (3) step(4'b0000, 1, 0, 0, 0, 0);
        step(4'b0000, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1, 1, i, 0, 0);
        repeat (3) step(4'b0000, 1, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0000, 1, 0, 0, 0, 0);

        // mid-operation reset, then a response to a discarded ID
        step(4'b0011, 1, 0, 0, 0, 0);
        step(4'b0000, 1, 0, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);
        step(4'b0000, 1, 1, 0, 0, 0);
        step(4'b0000, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            vm = (m_ir_prev || $urandom_range(0, 24) == 0) ? NL'($urandom & $urandom) : '0;
            pick_resp(rv, rs);
            if (!rv && $urandom_range(0, 15) == 0) begin
                rv = 1; rs = $urandom_range(0, MI - 1);
            end
            step(vm, 1'($urandom_range(0, 3) != 0), rv, rs, 1'b0, 1'b0);
        end

        // finish: drain everything with in_finished asserted until done
        for (int c = 0; c < 300 && !m_done; c++) begin
            pick_resp(rv, rs);
            step('0, 1'b1, rv, rs, 1'b1, 1'b0);
        end
        repeat (3) step('0, 1'b1, 1'b0, 0, 1'b1, 1'b0);

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("final_done", 64'(done), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
